// File: rtl/key_step_ctrl.sv
// key_step_ctrl -- pushbutton front end for single-stepping a CPU.
//
// Two raw pushbuttons (step, mode) are synchronized and debounced. A press
// (debounced 1->0) of the mode key toggles between MANUAL single-step and
// RUN (auto-step every RUN_PERIOD cycles). In MANUAL, each step-key press
// issues one step pulse. halt suppresses all pulses and forces RUN back to
// MANUAL.
//
// Ports:
//   clk         in   single clock, all state on rising edge
//   resetn      in   asynchronous active-low reset
//   key_step_n  in   raw step pushbutton, 0 = pressed
//   key_mode_n  in   raw mode pushbutton, 0 = pressed
//   halt        in   synchronous halt request from the CPU
//   step_pulse  out  one-cycle step strobe (registered)
//   run_mode    out  1 = RUN, 0 = MANUAL (the FSM state itself)
//   step_count  out  number of step pulses issued, wraps at 16 bits
//
// step_pulse is a plain strobe with no handshake: the CPU must act on it in
// the cycle it is high; nothing is held or retried.

module key_step_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned RUN_PERIOD      = 5000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        key_step_n,
    input  logic        key_mode_n,
    input  logic        halt,
    output logic        step_pulse,
    output logic        run_mode,
    output logic [15:0] step_count
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RW = (RUN_PERIOD > 1) ? $clog2(RUN_PERIOD) : 1;
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RUN_LAST = RW'(RUN_PERIOD - 1);
    localparam int KEY_STEP = 0;
    localparam int KEY_MODE = 1;

    typedef enum logic {
        MANUAL = 1'b0,
        RUN    = 1'b1
    } state_e;

    logic [1:0]    keys_n;
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    stable_q, stable_d;
    logic [1:0]    press_q, press_d;
    logic [DW-1:0] db_cnt_q [2];
    logic [DW-1:0] db_cnt_d [2];
    state_e        state_q, state_d;
    logic [RW-1:0] timer_q, timer_d;
    logic          pulse_q, pulse_d;
    logic [15:0]   step_count_q, step_count_d;

    assign keys_n = {key_mode_n, key_step_n};

    // Debounce: the counter tracks how many consecutive edges the synchronized
    // level has disagreed with the stable level; any agreement restarts it.
    // A press is registered on the edge stable falls, so the FSM acts on the
    // following edge.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stable_d[i] = stable_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
            press_d[i] = stable_q[i] & ~stable_d[i];
        end
    end

    // Step FSM. In RUN, leaving for MANUAL takes priority over a timer wrap,
    // so a coincident wrap produces no pulse. halt blocks pulses outright;
    // a blocked manual press is simply lost.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pulse_d = 1'b0;
        case (state_q)
            MANUAL: begin
                if (press_q[KEY_MODE]) begin
                    state_d = RUN;
                    timer_d = '0;
                end else if (press_q[KEY_STEP] && !halt) begin
                    pulse_d = 1'b1;
                end
            end
            RUN: begin
                if (press_q[KEY_MODE] || halt) begin
                    state_d = MANUAL;
                    timer_d = '0;
                end else if (timer_q == RUN_LAST) begin
                    timer_d = '0;
                    pulse_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = MANUAL;
                timer_d = '0;
            end
        endcase
        // Never two pulses back to back, even for degenerate RUN_PERIOD.
        if (pulse_q) begin
            pulse_d = 1'b0;
        end
        step_count_d = step_count_q + {15'd0, pulse_d};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q      <= 2'b11;
            sync2_q      <= 2'b11;
            stable_q     <= 2'b11;
            press_q      <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
            state_q      <= MANUAL;
            timer_q      <= '0;
            pulse_q      <= 1'b0;
            step_count_q <= 16'h0000;
        end else begin
            sync1_q      <= keys_n;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            press_q      <= press_d;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            state_q      <= state_d;
            timer_q      <= timer_d;
            pulse_q      <= pulse_d;
            step_count_q <= step_count_d;
        end
    end

    assign step_pulse = pulse_q;
    assign run_mode   = (state_q == RUN);
    assign step_count = step_count_q;

endmodule

// File: tb/tb_key_step_ctrl.sv
// Bench for key_step_ctrl with DEBOUNCE_CYCLES = 4, RUN_PERIOD = 8.
// Stimulus pushes {expected edge index, expected step_count} for each pulse
// it should cause; a monitor pops one entry per observed pulse.
// Edge index: cyc counts rising edges; at a falling edge cyc is the index of
// the rising edge just passed.

module tb_key_step_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        key_step_n = 1'b1;
    logic        key_mode_n = 1'b1;
    logic        halt = 1'b0;
    logic        step_pulse;
    logic        run_mode;
    logic [15:0] step_count;

    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_count = 16'h0000;
    logic [47:0] exp_q[$];

    key_step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .RUN_PERIOD     (8)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .key_step_n(key_step_n),
        .key_mode_n(key_mode_n),
        .halt      (halt),
        .step_pulse(step_pulse),
        .run_mode  (run_mode),
        .step_count(step_count)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_pulse(input int unsigned edge_idx);
        exp_count = exp_count + 16'd1;
        exp_q.push_back({edge_idx, exp_count});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [47:0] e;
        if (step_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got pulse at edge %0d count %0h, expected none",
                         cyc, step_count);
            end else begin
                e = exp_q.pop_front();
                check("pulse_edge", 48'(cyc), 48'(e[47:16]));
                check("pulse_count", 48'(step_count), 48'(e[15:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_until(input int unsigned n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Asynchronous reset between edges; outputs must clear at once.
    task automatic do_reset(input logic hold_step);
        @(negedge clk);
        #2 resetn = 1'b0;
        key_step_n = hold_step ? 1'b0 : 1'b1;
        key_mode_n = 1'b1;
        halt = 1'b0;
        #1;
        check("rst_step_pulse", 48'(step_pulse), 48'd0);
        check("rst_run_mode", 48'(run_mode), 48'd0);
        check("rst_step_count", 48'(step_count), 48'd0);
        exp_count = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int unsigned c;
        int unsigned e;

        resetn = 1'b0;
        wait_cycles(3);
        check("init_step_pulse", 48'(step_pulse), 48'd0);
        check("init_run_mode", 48'(run_mode), 48'd0);
        check("init_step_count", 48'(step_count), 48'd0);
        resetn = 1'b1;
        wait_cycles(2);

        // Held step key: one pulse at edge +7, none while held.
        c = cyc;
        key_step_n = 1'b0;
        push_pulse(c + 7);
        wait_until(c + 30);
        check("t1_run_mode", 48'(run_mode), 48'd0);
        key_step_n = 1'b1;
        wait_until(c + 42);
        check("t1_count", 48'(step_count), 48'(exp_count));

        // Bounce: 3 low, 1 high, five times -> nothing.
        for (int i = 0; i < 5; i++) begin
            key_step_n = 1'b0;
            wait_cycles(3);
            key_step_n = 1'b1;
            wait_cycles(1);
        end
        wait_cycles(12);
        check("t2_bounce_count", 48'(step_count), 48'(exp_count));

        // Halt on the edge a manual press lands: press discarded.
        c = cyc;
        key_step_n = 1'b0;
        wait_until(c + 6);
        halt = 1'b1;
        wait_until(c + 7);
        halt = 1'b0;
        wait_until(c + 12);
        key_step_n = 1'b1;
        wait_cycles(12);
        check("t_halt_manual_count", 48'(step_count), 48'(exp_count));

        // RUN: pulses every 8 edges, halt returns to MANUAL.
        do_reset(1'b0);
        c = cyc;
        key_mode_n = 1'b0;
        push_pulse(c + 15);
        push_pulse(c + 23);
        push_pulse(c + 31);
        wait_until(c + 7);
        check("t3_run_mode_on", 48'(run_mode), 48'd1);
        wait_until(c + 10);
        key_mode_n = 1'b1;
        wait_until(c + 31);
        halt = 1'b1;
        wait_until(c + 32);
        halt = 1'b0;
        check("t3_run_mode_off", 48'(run_mode), 48'd0);
        wait_until(c + 60);
        check("t3_count", 48'(step_count), 48'd3);

        // Mode press lands on a timer wrap edge: MANUAL wins, no pulse.
        c = cyc;
        e = c + 7;
        key_mode_n = 1'b0;
        push_pulse(e + 8);
        wait_until(e);
        check("t4_run_mode_on", 48'(run_mode), 48'd1);
        wait_until(c + 10);
        key_mode_n = 1'b1;
        wait_until(e + 16 - 7);
        key_mode_n = 1'b0;
        wait_until(e + 16);
        check("t4_run_mode_off", 48'(run_mode), 48'd0);
        wait_until(e + 19);
        key_mode_n = 1'b1;
        wait_until(e + 40);
        check("t4_count", 48'(step_count), 48'(exp_count));

        // Count wrap 0xFFFF -> 0x0000 on a RUN pulse.
        c = cyc;
        e = c + 7;
        key_mode_n = 1'b0;
        wait_until(c + 10);
        key_mode_n = 1'b1;
        wait_until(e + 2);
        force dut.step_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.step_count_q;
        exp_count = 16'hFFFF;
        push_pulse(e + 8);
        wait_until(e + 9);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        check("t5_run_mode_off", 48'(run_mode), 48'd0);
        check("t5_count_wrap", 48'(step_count), 48'h0000);
        wait_cycles(10);

        // Reset in the middle of a step debounce.
        key_step_n = 1'b0;
        wait_cycles(4);
        do_reset(1'b0);
        wait_cycles(20);
        check("t6_count", 48'(step_count), 48'd0);

        // Reset in the middle of RUN.
        c = cyc;
        key_mode_n = 1'b0;
        push_pulse(c + 15);
        wait_until(c + 10);
        key_mode_n = 1'b1;
        wait_until(c + 19);
        check("t7_run_mode_pre", 48'(run_mode), 48'd1);
        do_reset(1'b0);
        wait_cycles(25);
        check("t7_run_mode", 48'(run_mode), 48'd0);
        check("t7_count", 48'(step_count), 48'd0);

        // Step key held across reset release: one fresh press.
        do_reset(1'b1);
        c = cyc;
        push_pulse(c + 7);
        wait_until(c + 20);
        key_step_n = 1'b1;
        wait_cycles(12);
        check("t8_count", 48'(step_count), 48'd1);

        check("queue_empty", 48'(exp_q.size()), 48'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
